// File: rtl/eth_mac_status_pkg.sv
// Shared definitions for the MAC status counter block: event index map,
// event vector type and a packing helper for the MAC/FIFO status signals.
package eth_mac_status_pkg;

  localparam int EV_TX_ERROR_UNDERFLOW = 0;
  localparam int EV_TX_FIFO_OVERFLOW   = 1;
  localparam int EV_TX_FIFO_BAD_FRAME  = 2;
  localparam int EV_TX_FIFO_GOOD_FRAME = 3;
  localparam int EV_RX_ERROR_BAD_FRAME = 4;
  localparam int EV_RX_ERROR_BAD_FCS   = 5;
  localparam int EV_RX_FIFO_OVERFLOW   = 6;
  localparam int EV_RX_FIFO_BAD_FRAME  = 7;
  localparam int EV_RX_FIFO_GOOD_FRAME = 8;
  localparam int EV_COUNT              = 9;

  typedef logic [EV_COUNT-1:0] ev_vec_t;

  typedef struct packed {
    logic tx_error_underflow;
    logic tx_fifo_overflow;
    logic tx_fifo_bad_frame;
    logic tx_fifo_good_frame;
    logic rx_error_bad_frame;
    logic rx_error_bad_fcs;
    logic rx_fifo_overflow;
    logic rx_fifo_bad_frame;
    logic rx_fifo_good_frame;
  } eth_mac_status_t;

  function automatic ev_vec_t pack_events(input eth_mac_status_t s);
    ev_vec_t v;
    v                        = '0;
    v[EV_TX_ERROR_UNDERFLOW] = s.tx_error_underflow;
    v[EV_TX_FIFO_OVERFLOW]   = s.tx_fifo_overflow;
    v[EV_TX_FIFO_BAD_FRAME]  = s.tx_fifo_bad_frame;
    v[EV_TX_FIFO_GOOD_FRAME] = s.tx_fifo_good_frame;
    v[EV_RX_ERROR_BAD_FRAME] = s.rx_error_bad_frame;
    v[EV_RX_ERROR_BAD_FCS]   = s.rx_error_bad_fcs;
    v[EV_RX_FIFO_OVERFLOW]   = s.rx_fifo_overflow;
    v[EV_RX_FIFO_BAD_FRAME]  = s.rx_fifo_bad_frame;
    v[EV_RX_FIFO_GOOD_FRAME] = s.rx_fifo_good_frame;
    return v;
  endfunction

endpackage

// File: rtl/eth_mac_status_counters_if.sv
// Bundle of event, sticky/irq and shadow-read signals between the control
// plane (master) and the status counter block (slave).
interface eth_mac_status_counters_if
  import eth_mac_status_pkg::*;
#(
  parameter int NUM_EVENTS  = EV_COUNT,
  parameter int COUNT_WIDTH = 16
);
  localparam int ADDR_WIDTH = $clog2(NUM_EVENTS);

  logic [NUM_EVENTS-1:0]  event_i;
  logic                   snapshot_i;
  logic                   rd_en_i;
  logic [ADDR_WIDTH-1:0]  rd_addr_i;
  logic                   rd_clear_i;
  logic [COUNT_WIDTH-1:0] rd_data_o;
  logic                   rd_valid_o;
  logic [NUM_EVENTS-1:0]  sticky_o;
  logic [NUM_EVENTS-1:0]  sticky_clr_i;
  logic [NUM_EVENTS-1:0]  irq_mask_i;
  logic                   irq_o;

  modport master (
    output event_i, snapshot_i, rd_en_i, rd_addr_i, rd_clear_i,
           sticky_clr_i, irq_mask_i,
    input  rd_data_o, rd_valid_o, sticky_o, irq_o
  );

  modport slave (
    input  event_i, snapshot_i, rd_en_i, rd_addr_i, rd_clear_i,
           sticky_clr_i, irq_mask_i,
    output rd_data_o, rd_valid_o, sticky_o, irq_o
  );
endinterface

// File: rtl/eth_status_counter.sv
// Single event counter with clear; clear with a coincident increment loads 1
// so the event is never lost. Saturates or wraps at all-ones.
module eth_status_counter #(
  parameter int COUNT_WIDTH = 16,
  parameter int SATURATE    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc_i,
  input  logic                   clr_i,
  output logic [COUNT_WIDTH-1:0] value_o
);

  logic [COUNT_WIDTH-1:0] value_q;
  logic [COUNT_WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = COUNT_WIDTH'(inc_i);
    end else if (inc_i) begin
      if (value_q == '1) begin
        value_d = (SATURATE != 0) ? value_q : '0;
      end else begin
        value_d = value_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/eth_mac_status_counters.sv
// MAC statistics block: per-event live counters, atomic shadow snapshot,
// registered shadow read with clear-on-read, sticky flags and masked irq.
module eth_mac_status_counters
  import eth_mac_status_pkg::*;
#(
  parameter int NUM_EVENTS  = EV_COUNT,
  parameter int COUNT_WIDTH = 16,
  parameter int SATURATE    = 1,
  localparam int ADDR_WIDTH = $clog2(NUM_EVENTS)
) (
  input logic                     clk,
  input logic                     rst,
  eth_mac_status_counters_if.slave bus
);

  logic [COUNT_WIDTH-1:0] live_value [NUM_EVENTS];
  logic [COUNT_WIDTH-1:0] shadow_q   [NUM_EVENTS];
  logic [COUNT_WIDTH-1:0] rd_data_q;
  logic [COUNT_WIDTH-1:0] rd_data_d;
  logic                   rd_valid_q;
  logic [NUM_EVENTS-1:0]  sticky_q;
  logic [NUM_EVENTS-1:0]  sticky_d;
  logic                   irq_q;
  logic                   irq_d;
  logic                   addr_in_range;

  assign addr_in_range = 32'(bus.rd_addr_i) < NUM_EVENTS;

  generate
    for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_cnt
      logic clr;
      assign clr = bus.rd_en_i & bus.rd_clear_i & addr_in_range &
                   (bus.rd_addr_i == ADDR_WIDTH'(gi));

      eth_status_counter #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .SATURATE    (SATURATE)
      ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (bus.event_i[gi]),
        .clr_i   (clr),
        .value_o (live_value[gi])
      );
    end
  endgenerate

  // Shadow takes the pre-edge live value; same-cycle increments land in live only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_EVENTS; i++) shadow_q[i] <= '0;
    end else if (bus.snapshot_i) begin
      for (int i = 0; i < NUM_EVENTS; i++) shadow_q[i] <= live_value[i];
    end
  end

  // Reads see the shadow as it was before any coincident snapshot.
  always_comb begin
    rd_data_d = '0;
    if (addr_in_range) rd_data_d = shadow_q[bus.rd_addr_i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en_i;
      if (bus.rd_en_i) rd_data_q <= rd_data_d;
    end
  end

  assign sticky_d = bus.event_i | (sticky_q & ~bus.sticky_clr_i);
  assign irq_d    = |(sticky_d & bus.irq_mask_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.rd_data_o  = rd_data_q;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.sticky_o   = sticky_q;
  assign bus.irq_o      = irq_q;

endmodule

// File: tb/tb_eth_mac_status_counters.sv
// Bench: directed vector table, corner-case sequences and random traffic on
// three instances (16-bit saturating, 4-bit saturating, 4-bit wrapping).
module tb_eth_mac_status_counters;
  import eth_mac_status_pkg::*;

  localparam int NE = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_mac_status_counters_if #(.NUM_EVENTS(NE), .COUNT_WIDTH(16)) bus ();
  eth_mac_status_counters_if #(.NUM_EVENTS(NE), .COUNT_WIDTH(4))  bus_sat ();
  eth_mac_status_counters_if #(.NUM_EVENTS(NE), .COUNT_WIDTH(4))  bus_wrap ();

  eth_mac_status_counters #(.NUM_EVENTS(NE), .COUNT_WIDTH(16), .SATURATE(1))
    dut (.clk(clk), .rst(rst), .bus(bus));
  eth_mac_status_counters #(.NUM_EVENTS(NE), .COUNT_WIDTH(4), .SATURATE(1))
    dut_sat (.clk(clk), .rst(rst), .bus(bus_sat));
  eth_mac_status_counters #(.NUM_EVENTS(NE), .COUNT_WIDTH(4), .SATURATE(0))
    dut_wrap (.clk(clk), .rst(rst), .bus(bus_wrap));

  assign bus_sat.event_i       = bus.event_i;
  assign bus_sat.snapshot_i    = bus.snapshot_i;
  assign bus_sat.rd_en_i       = bus.rd_en_i;
  assign bus_sat.rd_addr_i     = bus.rd_addr_i;
  assign bus_sat.rd_clear_i    = bus.rd_clear_i;
  assign bus_sat.sticky_clr_i  = bus.sticky_clr_i;
  assign bus_sat.irq_mask_i    = bus.irq_mask_i;
  assign bus_wrap.event_i      = bus.event_i;
  assign bus_wrap.snapshot_i   = bus.snapshot_i;
  assign bus_wrap.rd_en_i      = bus.rd_en_i;
  assign bus_wrap.rd_addr_i    = bus.rd_addr_i;
  assign bus_wrap.rd_clear_i   = bus.rd_clear_i;
  assign bus_wrap.sticky_clr_i = bus.sticky_clr_i;
  assign bus_wrap.irq_mask_i   = bus.irq_mask_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: counters as plain integers, one set per instance.
  int       cw [3] = '{16, 4, 4};
  int       sat[3] = '{1, 1, 0};
  int       live_m  [3][NE];
  int       shadow_m[3][NE];
  int       rdd_m   [3];
  bit       rdv_m;
  bit [8:0] sticky_m;
  bit       irq_m;

  typedef struct {
    logic [8:0]  ev;
    bit          snap;
    bit          rd_en;
    logic [3:0]  addr;
    bit          rd_clr;
    logic [8:0]  sclr;
    logic [8:0]  mask;
    bit          exp_valid;
    logic [15:0] exp_data;
    logic [8:0]  exp_sticky;
    bit          exp_irq;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      rdd_m[d] = 0;
      for (int n = 0; n < NE; n++) begin
        live_m[d][n]   = 0;
        shadow_m[d][n] = 0;
      end
    end
    rdv_m    = 0;
    sticky_m = '0;
    irq_m    = 0;
  endtask

  task automatic model_step();
    int a;
    a = int'(bus.rd_addr_i);
    for (int d = 0; d < 3; d++) begin
      int maxv;
      maxv = (1 << cw[d]) - 1;
      if (bus.rd_en_i) rdd_m[d] = (a < NE) ? shadow_m[d][a] : 0;
      if (bus.snapshot_i)
        for (int n = 0; n < NE; n++) shadow_m[d][n] = live_m[d][n];
      for (int n = 0; n < NE; n++) begin
        bit ev;
        ev = bus.event_i[n];
        if (bus.rd_en_i && bus.rd_clear_i && a == n) live_m[d][n] = ev ? 1 : 0;
        else if (ev) begin
          if (live_m[d][n] == maxv) live_m[d][n] = sat[d] ? maxv : 0;
          else live_m[d][n] = live_m[d][n] + 1;
        end
      end
    end
    rdv_m    = bus.rd_en_i;
    sticky_m = bus.event_i | (sticky_m & ~bus.sticky_clr_i);
    irq_m    = (sticky_m & bus.irq_mask_i) != 0;
  endtask

  task automatic compare_all();
    check("main_rd_valid", 32'(bus.rd_valid_o),      32'(rdv_m));
    check("main_rd_data",  32'(bus.rd_data_o),       32'(rdd_m[0]));
    check("main_sticky",   32'(bus.sticky_o),        32'(sticky_m));
    check("main_irq",      32'(bus.irq_o),           32'(irq_m));
    check("sat_rd_valid",  32'(bus_sat.rd_valid_o),  32'(rdv_m));
    check("sat_rd_data",   32'(bus_sat.rd_data_o),   32'(rdd_m[1]));
    check("sat_irq",       32'(bus_sat.irq_o),       32'(irq_m));
    check("wrap_rd_valid", 32'(bus_wrap.rd_valid_o), 32'(rdv_m));
    check("wrap_rd_data",  32'(bus_wrap.rd_data_o),  32'(rdd_m[2]));
    check("wrap_sticky",   32'(bus_wrap.sticky_o),   32'(sticky_m));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
  endtask

  task automatic set_in(input logic [8:0] ev, input bit snap, input bit rd_en,
                        input logic [3:0] addr, input bit rd_clr,
                        input logic [8:0] sclr, input logic [8:0] mask);
    bus.event_i      = ev;
    bus.snapshot_i   = snap;
    bus.rd_en_i      = rd_en;
    bus.rd_addr_i    = addr;
    bus.rd_clear_i   = rd_clr;
    bus.sticky_clr_i = sclr;
    bus.irq_mask_i   = mask;
  endtask

  task automatic idle(input logic [8:0] mask);
    set_in('0, 0, 0, 4'd0, 0, '0, mask);
  endtask

  task automatic apply_reset();
    idle('0);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    eth_mac_status_t s;
    logic [8:0] ev5, ev7, m7;

    s = '0;
    s.rx_error_bad_fcs = 1'b1;
    ev5 = pack_events(s);
    ev7 = 9'h080;
    m7  = 9'h080;

    //               ev   snap rd addr clr sclr   mask  val data sticky irq
    tbl[0]  = '{ev5, 0, 0, 4'd0,  0, 9'h000, 9'h000, 0, 16'd0, 9'h020, 0};
    tbl[1]  = '{ev5, 0, 0, 4'd0,  0, 9'h020, 9'h000, 0, 16'd0, 9'h020, 0};
    tbl[2]  = '{ev5, 0, 0, 4'd0,  0, 9'h000, 9'h000, 0, 16'd0, 9'h020, 0};
    tbl[3]  = '{'0,  1, 0, 4'd0,  0, 9'h000, 9'h000, 0, 16'd0, 9'h020, 0};
    tbl[4]  = '{'0,  0, 1, 4'd5,  0, 9'h000, 9'h000, 1, 16'd3, 9'h020, 0};
    tbl[5]  = '{'0,  0, 0, 4'd0,  0, 9'h000, 9'h000, 0, 16'd3, 9'h020, 0};
    tbl[6]  = '{ev7, 0, 0, 4'd0,  0, 9'h000, 9'h000, 0, 16'd3, 9'h0A0, 0};
    tbl[7]  = '{'0,  0, 0, 4'd0,  0, 9'h000, m7,     0, 16'd3, 9'h0A0, 1};
    tbl[8]  = '{ev7, 0, 0, 4'd0,  0, 9'h080, m7,     0, 16'd3, 9'h0A0, 1};
    tbl[9]  = '{'0,  0, 0, 4'd0,  0, 9'h0A0, m7,     0, 16'd3, 9'h000, 0};
    tbl[10] = '{'0,  0, 1, 4'd12, 0, 9'h000, m7,     1, 16'd0, 9'h000, 0};
    tbl[11] = '{'0,  0, 1, 4'd5,  1, 9'h000, m7,     1, 16'd3, 9'h000, 0};
    tbl[12] = '{'0,  1, 1, 4'd5,  0, 9'h000, m7,     1, 16'd3, 9'h000, 0};
    tbl[13] = '{'0,  0, 1, 4'd5,  0, 9'h000, m7,     1, 16'd0, 9'h000, 0};

    // Reset state while rst is held from time zero.
    idle('0);
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].ev, tbl[i].snap, tbl[i].rd_en, tbl[i].addr, tbl[i].rd_clr,
             tbl[i].sclr, tbl[i].mask);
      tick();
      check($sformatf("tbl%0d_valid", i),  32'(bus.rd_valid_o), 32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_data", i),   32'(bus.rd_data_o),  32'(tbl[i].exp_data));
      check($sformatf("tbl%0d_sticky", i), 32'(bus.sticky_o),   32'(tbl[i].exp_sticky));
      check($sformatf("tbl%0d_irq", i),    32'(bus.irq_o),      32'(tbl[i].exp_irq));
    end

    // 20 pulses on event 0: 16-bit -> 20, 4-bit saturating -> 15, 4-bit wrapping -> 4.
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(9'h001, 0, 0, 4'd0, 0, '0, '0);
      tick();
    end
    set_in('0, 1, 0, 4'd0, 0, '0, '0);
    tick();
    set_in('0, 0, 1, 4'd0, 0, '0, '0);
    tick();
    check("cnt20_main", 32'(bus.rd_data_o),      32'd20);
    check("cnt20_sat",  32'(bus_sat.rd_data_o),  32'd15);
    check("cnt20_wrap", 32'(bus_wrap.rd_data_o), 32'd4);

    // Clear-on-read with a coincident event keeps that event.
    for (int i = 0; i < 3; i++) begin
      set_in(9'h004, 0, 0, 4'd0, 0, '0, '0);
      tick();
    end
    set_in(9'h004, 0, 1, 4'd2, 1, '0, '0);
    tick();
    set_in('0, 1, 0, 4'd0, 0, '0, '0);
    tick();
    set_in('0, 0, 1, 4'd2, 0, '0, '0);
    tick();
    check("clr_evt_keep", 32'(bus.rd_data_o), 32'd1);

    // Reset mid-operation with counter at 10 and irq asserted.
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(9'h008, 0, 0, 4'd0, 0, '0, 9'h1FF);
      tick();
    end
    set_in('0, 1, 0, 4'd0, 0, '0, 9'h1FF);
    tick();
    set_in('0, 0, 1, 4'd3, 0, '0, 9'h1FF);
    tick();
    check("pre_rst_cnt", 32'(bus.rd_data_o), 32'd10);
    check("pre_rst_irq", 32'(bus.irq_o),     32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_data",   32'(bus.rd_data_o),  32'd0);
    check("async_rst_valid",  32'(bus.rd_valid_o), 32'd0);
    check("async_rst_sticky", 32'(bus.sticky_o),   32'd0);
    check("async_rst_irq",    32'(bus.irq_o),      32'd0);
    idle('0);
    #1;
    rst = 1'b0;
    set_in('0, 0, 1, 4'd12, 0, '0, '0);
    tick();
    check("oor_valid", 32'(bus.rd_valid_o), 32'd1);
    check("oor_data",  32'(bus.rd_data_o),  32'd0);

    // Random traffic against the model.
    idle('0);
    for (int i = 0; i < 3000; i++) begin
      bus.event_i      = 9'($urandom) & 9'($urandom);
      bus.snapshot_i   = ($urandom_range(0, 7) == 0);
      bus.rd_en_i      = ($urandom_range(0, 2) == 0);
      bus.rd_addr_i    = 4'($urandom);
      bus.rd_clear_i   = ($urandom_range(0, 3) == 0);
      bus.sticky_clr_i = 9'($urandom) & 9'($urandom) & 9'($urandom);
      if ($urandom_range(0, 15) == 0) bus.irq_mask_i = 9'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
